// File: rtl/ring_pkg.sv
// ring_pkg
//   Shared definitions for consumers of the one-hot ring counter.
//   - state_t  : phase-monitor FSM encodings (IDLE, ACQUIRE, LOCKED, FAULT)
//   - ERR_*    : first-fault cause codes reported on err_code
//   - rotl()   : rotate-left of the low w bits of a vector, used to predict
//                the next legal ring phase from the previous one
package ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_ORDER  = 2'b10;
  localparam logic [1:0] ERR_STALL  = 2'b11;

  // Widest ring the rotate helper supports; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Rotate the low w bits of v left by one; bits at or above w come back 0.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int               w);
    logic [MAX_W-1:0] r;
    r = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        if (i == w - 1) begin
          r[0] = v[i];
        end else begin
          r[i+1] = v[i];
        end
      end else begin
        r[i] = r[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// onehot_encoder
//   Combinational one-hot checker and binary encoder, reusable by any ring
//   consumer.
//   Ports:
//     vec        in  [WIDTH-1:0]          candidate one-hot vector
//     is_onehot  out                      exactly one bit of vec is set
//     index      out [$clog2(WIDTH)-1:0]  position of the set bit
//                                         (meaningful only when is_onehot=1)
module onehot_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     is_onehot,
  output logic [$clog2(WIDTH)-1:0] index
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_s;
  logic [IDX_W-1:0] idx_s;

  // Population count and OR-reduced positions; with a single set bit the OR
  // of positions is exactly that bit's index.
  always_comb begin
    cnt_s = {CNT_W{1'b0}};
    idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        cnt_s = cnt_s + CNT_W'(1);
        idx_s = idx_s | IDX_W'(i);
      end else begin
        cnt_s = cnt_s;
      end
    end
  end

  assign is_onehot = (cnt_s == CNT_W'(1));
  assign index     = idx_s;

endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches the phase of a one-hot ring counter, checks that every sampled
//   phase is one-hot and advances by exactly one rotate-left step, encodes
//   the phase to a binary index, counts full revolutions once locked, and
//   latches a sticky fault when the ring corrupts.
//
//   Optional build macro: RING_PHASE_MONITOR_AUTORECOVER_EN
//     defined   : in FAULT a one-hot sample restarts acquisition (err stays
//                 sticky until clr_err)
//     undefined : FAULT is left only through clr_err or reset
//
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   asynchronous active-low reset
//     en           in   phase-advance strobe; phase_in only sampled when 1
//     phase_in     in   [WIDTH-1:0] one-hot phase from the ring counter
//     clr_err      in   clears fault/sticky error, FSM back to IDLE
//     index        out  binary index of the last accepted phase
//     index_valid  out  locked and index current
//     locked       out  FSM in LOCKED
//     err          out  sticky fault flag
//     err_code     out  first-fault cause (ring_pkg ERR_*)
//     rev_count    out  revolutions completed while locked (wraps)
//     rev_pulse    out  one-cycle pulse per completed revolution
//   All outputs are registered: one cycle from a sampled phase to outputs.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int REV_CNT_W = 8,
  parameter int LOCK_CNT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     index_valid,
  output logic                     locked,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [REV_CNT_W-1:0]     rev_count,
  output logic                     rev_pulse
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int STEP_W = $clog2(LOCK_CNT + 1);

  state_t               state_r,     state_nx;
  logic [WIDTH-1:0]     prev_r,      prev_nx;
  logic [STEP_W-1:0]    step_r,      step_nx;
  logic [IDX_W-1:0]     index_r,     index_nx;
  logic                 err_r,       err_nx;
  logic [1:0]           err_code_r,  err_code_nx;
  logic [REV_CNT_W-1:0] rev_count_r, rev_count_nx;
  logic                 rev_pulse_r, rev_pulse_nx;
  logic                 locked_r;
  logic                 index_valid_r;

  logic                 onehot_s;
  logic [IDX_W-1:0]     enc_idx_s;
  logic [WIDTH-1:0]     rot_s;
  logic [1:0]           seq_cause_s;
  logic                 fault_s;
  logic [1:0]           fault_cause_s;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .vec       (phase_in),
    .is_onehot (onehot_s),
    .index     (enc_idx_s)
  );

  assign rot_s = WIDTH'(rotl(MAX_W'(prev_r), WIDTH));

  // Sequence check in priority order: one-hot, then stall, then order.
  always_comb begin
    seq_cause_s = ERR_NONE;
    if (!onehot_s) begin
      seq_cause_s = ERR_ONEHOT;
    end else if (phase_in == prev_r) begin
      seq_cause_s = ERR_STALL;
    end else if (phase_in != rot_s) begin
      seq_cause_s = ERR_ORDER;
    end else begin
      seq_cause_s = ERR_NONE;
    end
  end

  // Next-state, datapath and fault bookkeeping.
  always_comb begin
    state_nx      = state_r;
    prev_nx       = prev_r;
    step_nx       = step_r;
    index_nx      = index_r;
    err_nx        = err_r;
    err_code_nx   = err_code_r;
    rev_count_nx  = rev_count_r;
    rev_pulse_nx  = 1'b0;
    fault_s       = 1'b0;
    fault_cause_s = ERR_NONE;

    case (state_r)
      ST_IDLE: begin
        // prev is meaningless here, so only one-hot legality is checked.
        if (en) begin
          if (onehot_s) begin
            state_nx = ST_ACQUIRE;
            prev_nx  = phase_in;
            step_nx  = {STEP_W{1'b0}};
            index_nx = enc_idx_s;
          end else begin
            fault_s       = 1'b1;
            fault_cause_s = ERR_ONEHOT;
          end
        end else begin
          state_nx = state_r;
        end
      end

      ST_ACQUIRE: begin
        if (en) begin
          if (seq_cause_s == ERR_NONE) begin
            prev_nx  = phase_in;
            index_nx = enc_idx_s;
            step_nx  = step_r + STEP_W'(1);
            if (step_r == STEP_W'(LOCK_CNT - 1)) begin
              state_nx = ST_LOCKED;
            end else begin
              state_nx = ST_ACQUIRE;
            end
          end else begin
            fault_s       = 1'b1;
            fault_cause_s = seq_cause_s;
          end
        end else begin
          state_nx = state_r;
        end
      end

      ST_LOCKED: begin
        if (en) begin
          if (seq_cause_s == ERR_NONE) begin
            prev_nx  = phase_in;
            index_nx = enc_idx_s;
            // Wrapping from the top bit back to bit 0 closes a revolution.
            if (prev_r[WIDTH-1]) begin
              rev_count_nx = rev_count_r + REV_CNT_W'(1);
              rev_pulse_nx = 1'b1;
            end else begin
              rev_count_nx = rev_count_r;
            end
          end else begin
            fault_s       = 1'b1;
            fault_cause_s = seq_cause_s;
          end
        end else begin
          state_nx = state_r;
        end
      end

      ST_FAULT: begin
        // prev is stale after a fault, so only one-hot legality matters.
        if (en && !onehot_s) begin
          fault_s       = 1'b1;
          fault_cause_s = ERR_ONEHOT;
        end else if (clr_err) begin
          state_nx    = ST_IDLE;
          err_nx      = 1'b0;
          err_code_nx = ERR_NONE;
          prev_nx     = {WIDTH{1'b0}};
          step_nx     = {STEP_W{1'b0}};
        end else begin
`ifdef RING_PHASE_MONITOR_AUTORECOVER_EN
          if (en) begin
            state_nx = ST_ACQUIRE;
            prev_nx  = phase_in;
            step_nx  = {STEP_W{1'b0}};
            index_nx = enc_idx_s;
          end else begin
            state_nx = state_r;
          end
`else
          state_nx = state_r;
`endif
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Only the first cause is kept, unless this very cycle clears the fault.
    if (fault_s) begin
      state_nx = ST_FAULT;
      err_nx   = 1'b1;
      if (!err_r || ((state_r == ST_FAULT) && clr_err)) begin
        err_code_nx = fault_cause_s;
      end else begin
        err_code_nx = err_code_r;
      end
    end else begin
      err_nx = err_nx;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      prev_r        <= {WIDTH{1'b0}};
      step_r        <= {STEP_W{1'b0}};
      index_r       <= {IDX_W{1'b0}};
      err_r         <= 1'b0;
      err_code_r    <= ERR_NONE;
      rev_count_r   <= {REV_CNT_W{1'b0}};
      rev_pulse_r   <= 1'b0;
      locked_r      <= 1'b0;
      index_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nx;
      prev_r        <= prev_nx;
      step_r        <= step_nx;
      index_r       <= index_nx;
      err_r         <= err_nx;
      err_code_r    <= err_code_nx;
      rev_count_r   <= rev_count_nx;
      rev_pulse_r   <= rev_pulse_nx;
      locked_r      <= (state_nx == ST_LOCKED);
      index_valid_r <= (state_nx == ST_LOCKED);
    end
  end

  assign index       = index_r;
  assign index_valid = index_valid_r;
  assign locked      = locked_r;
  assign err         = err_r;
  assign err_code    = err_code_r;
  assign rev_count   = rev_count_r;
  assign rev_pulse   = rev_pulse_r;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor
//   Directed-vector bench for ring_phase_monitor (WIDTH=4, REV_CNT_W=2,
//   LOCK_CNT=2). Expected values are hand-computed constants.
module tb_ring_phase_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] phase_in;
  logic       clr_err;
  logic [1:0] index;
  logic       index_valid;
  logic       locked;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] rev_count;
  logic       rev_pulse;

  int n_vec;
  int n_err;

  ring_phase_monitor #(
    .WIDTH     (4),
    .REV_CNT_W (2),
    .LOCK_CNT  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_in    (phase_in),
    .clr_err     (clr_err),
    .index       (index),
    .index_valid (index_valid),
    .locked      (locked),
    .err         (err),
    .err_code    (err_code),
    .rev_count   (rev_count),
    .rev_pulse   (rev_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after an edge, then settle past the next edge.
  task automatic apply(input logic e, input logic [3:0] p, input logic c);
    en       = e;
    phase_in = p;
    clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int pulses;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    en       = 1'b0;
    phase_in = 4'b0000;
    clr_err  = 1'b0;
    do_reset();

    // Reset state
    chk("rst_index",  32'(index),       32'd0);
    chk("rst_valid",  32'(index_valid), 32'd0);
    chk("rst_locked", 32'(locked),      32'd0);
    chk("rst_err",    32'(err),         32'd0);
    chk("rst_code",   32'(err_code),    32'd0);
    chk("rst_rev",    32'(rev_count),   32'd0);
    chk("rst_pulse",  32'(rev_pulse),   32'd0);

    // 1: acquire and lock, one revolution
    apply(1'b1, 4'b0001, 1'b0);
    chk("t1_idx0", 32'(index), 32'd0);
    chk("t1_lk0",  32'(locked), 32'd0);
    apply(1'b1, 4'b0010, 1'b0);
    chk("t1_idx1", 32'(index), 32'd1);
    chk("t1_lk1",  32'(locked), 32'd0);
    apply(1'b1, 4'b0100, 1'b0);
    chk("t1_idx2", 32'(index), 32'd2);
    chk("t1_lk2",  32'(locked), 32'd1);
    chk("t1_val2", 32'(index_valid), 32'd1);
    apply(1'b1, 4'b1000, 1'b0);
    chk("t1_idx3", 32'(index), 32'd3);
    chk("t1_pl3",  32'(rev_pulse), 32'd0);
    apply(1'b1, 4'b0001, 1'b0);
    chk("t1_idx4", 32'(index), 32'd0);
    chk("t1_pl4",  32'(rev_pulse), 32'd1);
    chk("t1_rev4", 32'(rev_count), 32'd1);
    // en=0 with an illegal phase: ignored, pulse drops
    apply(1'b0, 4'b0000, 1'b0);
    chk("t1_en0_pl",  32'(rev_pulse), 32'd0);
    chk("t1_en0_lk",  32'(locked), 32'd1);
    chk("t1_en0_err", 32'(err), 32'd0);

    // 2: not one-hot while locked
    apply(1'b1, 4'b0110, 1'b0);
    chk("t2_err",  32'(err), 32'd1);
    chk("t2_code", 32'(err_code), 32'd1);
    chk("t2_lk",   32'(locked), 32'd0);
    chk("t2_val",  32'(index_valid), 32'd0);
    chk("t2_idx",  32'(index), 32'd0);
    apply(1'b1, 4'b0011, 1'b0);
    chk("t2_keep", 32'(err_code), 32'd1);

    // clr_err alone: back to IDLE, rev_count kept
    apply(1'b0, 4'b0000, 1'b1);
    chk("t4_clr_err",  32'(err), 32'd0);
    chk("t4_clr_code", 32'(err_code), 32'd0);
    chk("t4_clr_rev",  32'(rev_count), 32'd1);

    // 3a: lock, reach 0010, then skip to 1000
    apply(1'b1, 4'b0001, 1'b0);
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    apply(1'b1, 4'b1000, 1'b0);
    apply(1'b1, 4'b0001, 1'b0);
    chk("t3_rev", 32'(rev_count), 32'd2);
    apply(1'b1, 4'b0010, 1'b0);
    chk("t3_lk", 32'(locked), 32'd1);
    apply(1'b1, 4'b1000, 1'b0);
    chk("t3_skip_code", 32'(err_code), 32'd2);
    chk("t3_skip_lk",   32'(locked), 32'd0);
    apply(1'b0, 4'b0000, 1'b1);
    chk("t3_clr", 32'(err), 32'd0);

    // 3b: lock at 0010 then repeat it (stall)
    apply(1'b1, 4'b0100, 1'b0);
    apply(1'b1, 4'b1000, 1'b0);
    apply(1'b1, 4'b0001, 1'b0);
    chk("t3_lk_norev", 32'(rev_count), 32'd2);
    apply(1'b1, 4'b0010, 1'b0);
    chk("t3_lk2",  32'(locked), 32'd1);
    chk("t3_idx2", 32'(index), 32'd1);
    apply(1'b1, 4'b0010, 1'b0);
    chk("t3_stall_code", 32'(err_code), 32'd3);
    chk("t3_stall_err",  32'(err), 32'd1);

    // 4: clr_err together with an illegal sample: error wins, new cause
    apply(1'b1, 4'b0000, 1'b1);
    chk("t4_win_err",  32'(err), 32'd1);
    chk("t4_win_code", 32'(err_code), 32'd1);
    chk("t4_win_lk",   32'(locked), 32'd0);
    apply(1'b0, 4'b0000, 1'b1);
    chk("t4_clr2", 32'(err), 32'd0);

    // 5: 2-bit revolution counter wraps after 4 clean revolutions
    do_reset();
    apply(1'b1, 4'b0001, 1'b0);
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    pulses = 0;
    for (int r = 1; r <= 4; r++) begin
      apply(1'b1, 4'b1000, 1'b0);
      if (rev_pulse) pulses++;
      apply(1'b1, 4'b0001, 1'b0);
      if (rev_pulse) pulses++;
      chk($sformatf("t5_rev%0d", r), 32'(rev_count), 32'(r % 4));
      if (r < 4) begin
        apply(1'b1, 4'b0010, 1'b0);
        if (rev_pulse) pulses++;
        apply(1'b1, 4'b0100, 1'b0);
        if (rev_pulse) pulses++;
      end else begin
        pulses = pulses;
      end
    end
    chk("t5_pulses", 32'(pulses), 32'd4);
    // Mid-revolution async reset, checked before the next clock edge
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    chk("t5_pre_lk", 32'(locked), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_arst_idx", 32'(index),     32'd0);
    chk("t5_arst_lk",  32'(locked),    32'd0);
    chk("t5_arst_val", 32'(index_valid), 32'd0);
    chk("t5_arst_rev", 32'(rev_count), 32'd0);
    chk("t5_arst_err", 32'(err),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 6: fault then a fresh legal sequence
    apply(1'b1, 4'b0001, 1'b0);
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    apply(1'b1, 4'b0000, 1'b0);
    chk("t6_code", 32'(err_code), 32'd1);
    apply(1'b1, 4'b0100, 1'b0);
    apply(1'b1, 4'b1000, 1'b0);
    apply(1'b1, 4'b0001, 1'b0);
    chk("t6_err",  32'(err), 32'd1);
    chk("t6_code2", 32'(err_code), 32'd1);
`ifdef RING_PHASE_MONITOR_AUTORECOVER_EN
    chk("t6_lk",  32'(locked), 32'd1);
    chk("t6_idx", 32'(index), 32'd0);
`else
    chk("t6_lk",  32'(locked), 32'd0);
    chk("t6_idx", 32'(index), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-bit one-hot ring counter. It samples the ring phase, checks that the phase is legal one-hot and advances in rotation order, encodes the phase to a binary index, and counts full revolutions. It also raises a fault when the ring corrupts. It sits between the ring counter and the phase-driven logic, such as display scan and round-robin slot select, which must only act on a locked, trusted phase.

Parameters:
WIDTH, 4, ring width; one-hot phase bits (>=2)
REV_CNT_W, 8, width of the revolution counter
LOCK_CNT, 2, consecutive correct rotations required to declare lock (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
en  input  1  phase-advance strobe; phase_in is checked only when en=1
phase_in  input  WIDTH  one-hot phase from the ring counter
clr_err  input  1  clears fault and sticky error; returns FSM to IDLE
index  output  $clog2(WIDTH)  binary position of the set bit of the last legal sample
index_valid  output  1  1 when locked and index is current
locked  output  1  FSM in LOCKED
err  output  1  sticky fault flag
err_code  output  2  first-fault cause: 00 none, 01 not one-hot, 10 wrong order, 11 stall
rev_count  output  REV_CNT_W  completed revolutions while locked; wraps
rev_pulse  output  1  one-cycle pulse on each completed revolution

Behaviour:
- Reset (rst=0, async): FSM=IDLE, prev=0, index=0, index_valid=0, locked=0, err=0, err_code=00, rev_count=0, rev_pulse=0, step counter=0. Mid-operation reset clears everything immediately.
- All outputs are registered. One cycle of latency from a sampled phase_in (en=1) to the outputs.
- en=0: no state change. rev_pulse is forced to 0. phase_in is ignored, even if it is illegal.
- Checks are applied to a sample taken with en=1, in priority order:
  - not one-hot (zero bits or more than one bit set) -> cause 01.
  - phase_in == prev -> stall, cause 11.
  - phase_in != rotate-left(prev), i.e. {prev[WIDTH-2:0],prev[WIDTH-1]} -> cause 10.
- FSM states and transitions:
  - IDLE: first legal one-hot sample -> prev=phase_in, step=0, go to ACQUIRE. An illegal sample -> FAULT with cause 01.
  - ACQUIRE: each correct rotation increments step. When step reaches LOCK_CNT -> LOCKED. Any failed check -> FAULT.
  - LOCKED: index_valid=1. Any failed check -> FAULT.
  - FAULT: err=1. err_code holds the first cause only; later errors do not overwrite it. clr_err -> IDLE with err=0 and err_code=00. rev_count is kept.
- Revolution: in LOCKED, a correct rotation from prev[WIDTH-1] to phase_in[0] increments rev_count (modulo 2^REV_CNT_W, wraps silently) and pulses rev_pulse.
- index updates on every legal one-hot sample. It is frozen while in FAULT.
- clr_err in the same cycle as an en=1 illegal sample: the error wins, and the FSM enters or stays in FAULT with the new cause.
- clr_err outside FAULT: no effect.

Optional Feature:
RING_PHASE_MONITOR_AUTORECOVER_EN
- Defined: in FAULT, a legal one-hot sample moves the FSM to ACQUIRE with prev=phase_in and step=0. err stays sticky until clr_err.
- Not defined: FAULT is left only via clr_err or reset.

Decomposition:
- Shared package/include ring_pkg:
  - FSM state encodings: IDLE, ACQUIRE, LOCKED, FAULT.
  - err_code constants: ERR_NONE, ERR_ONEHOT, ERR_ORDER, ERR_STALL.
  - A rotate-left function.
- One sub-module, onehot_encoder (combinational):
  - inputs: WIDTH vector.
  - outputs: is_onehot and a binary index.
  - reusable by other ring consumers.

Test Plan:
1. Reset then en=1 with phase 0001,0010,0100,1000,0001 -> locked=1 after the 3rd sample's output cycle. index follows 0,1,2,3,0. rev_pulse=1 once; rev_count=1.
2. While locked, inject phase 0110 with en=1 -> next cycle err=1, err_code=01, locked=0, index held at its last value. A following 0011 keeps err_code=01.
3. Locked at 0010, then inject 1000 (skip) -> err_code=10. Separately, repeat 0010 -> err_code=11. Toggle en=0 while phase_in=0000 -> no error.
4. In FAULT, assert clr_err alone -> IDLE, err=0, rev_count unchanged. Assert clr_err together with an en=1 sample of 0000 -> stays FAULT, err_code=01.
5. REV_CNT_W=2: run 4 clean revolutions -> rev_count 1,2,3,0 with 4 rev_pulses. Drop rst low mid-revolution -> all outputs 0 asynchronously, before the next clk edge.
6. With AUTORECOVER_EN defined: fault, then feed 0100,1000,0001 -> relocks with err still 1. Without it -> stays FAULT.
